mem_arbiter: RTL and testbench

- Sequences the single shared main-memory port between the instruction-cache miss path and the data-cache miss/write path of the pipelined CPU.
- Performs atomic 8-word line fills for either requester.
- Performs single-word write-through stores for the data side.
- Sits between both cache controllers and the multi-cycle pipelined main memory. The pipeline stalls on the requesting cache until that cache's done pulse.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_arbiter_if.sv | 52 +++++
 rtl/mem_arb_fill_ctr.sv | 55 +++++
 rtl/mem_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_arbiter.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mem_arb_pkg: shared types and widths for the memory port arbiter.     |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FILL_I  = 2'd1,
    ST_FILL_D  = 2'd2,
    ST_WRITE_D = 2'd3
  } arb_state_e;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_e;

  localparam int DEF_WORDS_PER_LINE = 8;
  localparam int LINE_OFF_W         = $clog2(DEF_WORDS_PER_LINE);
  localparam int WORD_OFF_W         = 1;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mem_arbiter_if: I-cache, D-cache and main-memory signals of arbiter.  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
);
  localparam int IDX_W = $clog2(WORDS_PER_LINE);

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_fill_valid;
  logic [IDX_W-1:0]  i_fill_idx;
  logic [15:0]       i_fill_data;
  logic              i_done;

  logic              d_req;
  logic              d_wr;
  logic [ADDR_W-1:0] d_addr;
  logic [15:0]       d_wdata;
  logic              d_fill_valid;
  logic [IDX_W-1:0]  d_fill_idx;
  logic [15:0]       d_fill_data;
  logic              d_done;

  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata;
  logic              mem_rvalid;

  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_rvalid,
    output i_fill_valid, i_fill_idx, i_fill_data, i_done,
           d_fill_valid, d_fill_idx, d_fill_data, d_done,
           mem_en, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_rvalid,
    input  i_fill_valid, i_fill_idx, i_fill_data, i_done,
           d_fill_valid, d_fill_idx, d_fill_data, d_done,
           mem_en, mem_wr, mem_addr, mem_wdata
  );

endinterface
`default_nettype wire

// File: rtl/mem_arb_fill_ctr.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mem_arb_fill_ctr: issue/return word counters shared by both fills.    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module mem_arb_fill_ctr
  import mem_arb_pkg::*;
#(
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter int IDX_W          = $clog2(WORDS_PER_LINE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             issue_inc_i,
  input  logic             ret_inc_i,
  output logic [IDX_W-1:0] issue_idx_o,
  output logic             issuing_o,
  output logic [IDX_W-1:0] ret_idx_o,
  output logic             ret_last_o
);

  // Extra MSB marks "all words issued" so issuing stops after the last read.
  logic [IDX_W:0]   issue_q, issue_d;
  logic [IDX_W-1:0] ret_q, ret_d;

  always_comb begin
    issue_d = issue_q;
    ret_d   = ret_q;
    if (clr_i) begin
      issue_d = '0;
      ret_d   = '0;
    end else begin
      if (issue_inc_i) issue_d = issue_q + 1'b1;
      if (ret_inc_i)   ret_d   = ret_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_q <= '0;
      ret_q   <= '0;
    end else begin
      issue_q <= issue_d;
      ret_q   <= ret_d;
    end
  end

  assign issue_idx_o = issue_q[IDX_W-1:0];
  assign issuing_o   = ~issue_q[IDX_W];
  assign ret_idx_o   = ret_q;
  assign ret_last_o  = (ret_q == IDX_W'(WORDS_PER_LINE - 1));

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mem_arbiter: shares main memory between I-cache fills and D-cache     |
// | fills/writes. MEM_ARB_ROUND_ROBIN_EN selects round-robin tie-breaking.|
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus,
  output logic          busy
);

  localparam int IDX_W = $clog2(WORDS_PER_LINE);
  localparam int TAG_W = ADDR_W - IDX_W - WORD_OFF_W;

  localparam logic [1:0] S_IDLE    = 2'(ST_IDLE);
  localparam logic [1:0] S_FILL_I  = 2'(ST_FILL_I);
  localparam logic [1:0] S_FILL_D  = 2'(ST_FILL_D);
  localparam logic [1:0] S_WRITE_D = 2'(ST_WRITE_D);

  logic [1:0]       state_q, state_d;
  logic             in_fill_i, in_fill_d, in_fill, in_write;
  logic             pick_d;
  logic             issuing, ret_last, fill_rvalid, fill_last;
  logic [IDX_W-1:0] issue_idx, ret_idx;
  logic [TAG_W-1:0] line_tag;
  logic             unused_addr_bits;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  req_id_e last_grant_q, last_grant_d;

  // On a tie, the side that was not granted last time goes first.
  assign pick_d = bus.d_req && !(bus.i_req && (last_grant_q == REQ_D));

  always_comb begin
    last_grant_d = last_grant_q;
    if ((state_q == S_IDLE) && (bus.d_req || bus.i_req))
      last_grant_d = pick_d ? REQ_D : REQ_I;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant_q <= REQ_I;
    else     last_grant_q <= last_grant_d;
  end
`else
  assign pick_d = bus.d_req;
`endif

  assign in_fill_i   = (state_q == S_FILL_I);
  assign in_fill_d   = (state_q == S_FILL_D);
  assign in_fill     = in_fill_i | in_fill_d;
  assign in_write    = (state_q == S_WRITE_D);
  assign fill_rvalid = in_fill & bus.mem_rvalid;
  assign fill_last   = fill_rvalid & ret_last;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (pick_d)         state_d = bus.d_wr ? S_WRITE_D : S_FILL_D;
        else if (bus.i_req) state_d = S_FILL_I;
      end
      S_FILL_I, S_FILL_D: if (fill_last) state_d = S_IDLE;
      S_WRITE_D:          state_d = S_IDLE;
      default:            state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  mem_arb_fill_ctr #(
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .IDX_W          (IDX_W)
  ) u_fill_ctr (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (fill_last),
    .issue_inc_i (in_fill & issuing),
    .ret_inc_i   (fill_rvalid),
    .issue_idx_o (issue_idx),
    .issuing_o   (issuing),
    .ret_idx_o   (ret_idx),
    .ret_last_o  (ret_last)
  );

  // Line offset bits of the request address are replaced by the issue index.
  assign line_tag = in_fill_d ? bus.d_addr[ADDR_W-1:IDX_W+WORD_OFF_W]
                              : bus.i_addr[ADDR_W-1:IDX_W+WORD_OFF_W];
  assign unused_addr_bits = &{1'b0, bus.i_addr[IDX_W+WORD_OFF_W-1:0]};

  assign bus.mem_en    = (in_fill & issuing) | in_write;
  assign bus.mem_wr    = in_write;
  assign bus.mem_addr  = in_write             ? bus.d_addr :
                         (in_fill & issuing)  ? {line_tag, issue_idx, {WORD_OFF_W{1'b0}}} :
                                                '0;
  assign bus.mem_wdata = in_write ? bus.d_wdata : '0;

  assign bus.i_fill_valid = in_fill_i & bus.mem_rvalid;
  assign bus.i_fill_idx   = bus.i_fill_valid ? ret_idx : '0;
  assign bus.i_fill_data  = bus.i_fill_valid ? bus.mem_rdata : '0;
  assign bus.i_done       = in_fill_i & fill_last;

  assign bus.d_fill_valid = in_fill_d & bus.mem_rvalid;
  assign bus.d_fill_idx   = bus.d_fill_valid ? ret_idx : '0;
  assign bus.d_fill_data  = bus.d_fill_valid ? bus.mem_rdata : '0;
  assign bus.d_done       = (in_fill_d & fill_last) | in_write;

  assign busy = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_mem_arbiter: directed bench with a 4-cycle pipelined memory model. |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_mem_arbiter;

  logic clk;
  logic rst;
  logic busy;
  logic inj;
  int   compared;
  int   mismatched;

  mem_arbiter_if #(.ADDR_W(16), .WORDS_PER_LINE(8)) bus ();

  mem_arbiter #(.ADDR_W(16), .WORDS_PER_LINE(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: read data appears 4 cycles after the issuing cycle, data = addr ^ A5A5.
  logic [3:0]  pv;
  logic [15:0] pa [4];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pv <= 4'b0;
    end else begin
      pv    <= {pv[2:0], bus.mem_en & ~bus.mem_wr};
      pa[0] <= bus.mem_addr;
      pa[1] <= pa[0];
      pa[2] <= pa[1];
      pa[3] <= pa[2];
    end
  end
  assign bus.mem_rvalid = pv[3] | inj;
  assign bus.mem_rdata  = inj ? 16'hDEAD : (pv[3] ? (pa[3] ^ 16'hA5A5) : 16'h0000);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Starts in the IDLE cycle in which the winning request is already visible.
  task automatic run_fill(input bit dside, input logic [15:0] addr,
                          input int drop_at, input bit drop_other);
    logic [15:0] base;
    logic [15:0] wa;
    base = {addr[15:4], 4'h0};
    for (int c = 1; c <= 13; c++) begin
      cyc();
      wa = base + 16'(2 * (c - 5));
      chk("mem_en",    bus.mem_en, (c <= 8));
      chk("mem_addr",  bus.mem_addr, (c <= 8) ? base + 16'(2 * (c - 1)) : 16'h0);
      chk("mem_wr",    bus.mem_wr, 1'b0);
      chk("mem_wdata", bus.mem_wdata, 16'h0);
      chk("own_fv",    dside ? bus.d_fill_valid : bus.i_fill_valid, (c >= 5 && c <= 12));
      chk("own_idx",   dside ? bus.d_fill_idx : bus.i_fill_idx, (c >= 5 && c <= 12) ? 3'(c - 5) : 3'd0);
      chk("own_data",  dside ? bus.d_fill_data : bus.i_fill_data,
          (c >= 5 && c <= 12) ? (wa ^ 16'hA5A5) : 16'h0);
      chk("own_done",  dside ? bus.d_done : bus.i_done, (c == 12));
      chk("oth_fv",    dside ? bus.i_fill_valid : bus.d_fill_valid, 1'b0);
      chk("oth_done",  dside ? bus.i_done : bus.d_done, 1'b0);
      chk("busy",      busy, (c <= 12));
      if (c == drop_at) begin
        if (dside) bus.d_req = 1'b0;
        else       bus.i_req = 1'b0;
      end
      if (c == 12 && drop_other) begin
        if (dside) bus.i_req = 1'b0;
        else       bus.d_req = 1'b0;
      end
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    inj        = 1'b0;
    rst        = 1'b1;
    bus.i_req  = 1'b0;
    bus.i_addr = 16'h0;
    bus.d_req  = 1'b0;
    bus.d_wr   = 1'b0;
    bus.d_addr = 16'h0;
    bus.d_wdata = 16'h0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_busy",   busy, 1'b0);
    chk("rst_mem_en", bus.mem_en, 1'b0);
    chk("rst_addr",   bus.mem_addr, 16'h0);
    chk("rst_i_done", bus.i_done, 1'b0);
    chk("rst_d_done", bus.d_done, 1'b0);
    chk("rst_i_fv",   bus.i_fill_valid, 1'b0);

    // Simultaneous requests: D fill first, then I fill.
    bus.i_req  = 1'b1;
    bus.i_addr = 16'h3456;
    bus.d_req  = 1'b1;
    bus.d_wr   = 1'b0;
    bus.d_addr = 16'h2000;
    run_fill(1'b1, 16'h2000, 12, 1'b0);
    run_fill(1'b0, 16'h3456, 12, 1'b0);

    // Single-word write, with a spurious rvalid during the write cycle.
    bus.d_req   = 1'b1;
    bus.d_wr    = 1'b1;
    bus.d_addr  = 16'h0040;
    bus.d_wdata = 16'hBEEF;
    #1;
    chk("wr_idle_wdata", bus.mem_wdata, 16'h0);
    chk("wr_idle_en",    bus.mem_en, 1'b0);
    cyc();
    inj = 1'b1;
    #1;
    chk("wr_en",    bus.mem_en, 1'b1);
    chk("wr_wr",    bus.mem_wr, 1'b1);
    chk("wr_addr",  bus.mem_addr, 16'h0040);
    chk("wr_wdata", bus.mem_wdata, 16'hBEEF);
    chk("wr_done",  bus.d_done, 1'b1);
    chk("wr_busy",  busy, 1'b1);
    chk("wr_d_fv",  bus.d_fill_valid, 1'b0);
    chk("wr_i_fv",  bus.i_fill_valid, 1'b0);
    inj       = 1'b0;
    bus.d_req = 1'b0;
    cyc();
    chk("wr_after_busy",  busy, 1'b0);
    chk("wr_after_done",  bus.d_done, 1'b0);
    chk("wr_after_wdata", bus.mem_wdata, 16'h0);

    // Second tie right after a D grant.
    bus.d_wr   = 1'b0;
    bus.d_addr = 16'h2000;
    bus.i_addr = 16'h3456;
    bus.d_req  = 1'b1;
    bus.i_req  = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    run_fill(1'b0, 16'h3456, 12, 1'b1);
`else
    run_fill(1'b1, 16'h2000, 12, 1'b1);
`endif

    // Plain I fill with wrapped line base.
    bus.i_req  = 1'b1;
    bus.i_addr = 16'h1234;
    run_fill(1'b0, 16'h1234, 12, 1'b0);

    // Reset in cycle 6 of an I fill, then refill.
    bus.i_req  = 1'b1;
    bus.i_addr = 16'h1234;
    repeat (6) cyc();
    chk("pre_rst_en", bus.mem_en, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_en",   bus.mem_en, 1'b0);
    chk("mid_rst_addr", bus.mem_addr, 16'h0);
    chk("mid_rst_fv",   bus.i_fill_valid, 1'b0);
    chk("mid_rst_done", bus.i_done, 1'b0);
    cyc();
    chk("in_rst_done", bus.i_done, 1'b0);
    chk("in_rst_fv",   bus.i_fill_valid, 1'b0);
    rst = 1'b0;
    #1;
    run_fill(1'b0, 16'h1234, 12, 1'b0);

    // Request dropped in cycle 3: fill still completes.
    bus.i_req  = 1'b1;
    bus.i_addr = 16'hABCE;
    run_fill(1'b0, 16'hABCE, 3, 1'b0);

    // Spurious rvalid in IDLE.
    inj = 1'b1;
    #1;
    chk("spur_i_fv",   bus.i_fill_valid, 1'b0);
    chk("spur_d_fv",   bus.d_fill_valid, 1'b0);
    chk("spur_i_done", bus.i_done, 1'b0);
    chk("spur_d_done", bus.d_done, 1'b0);
    chk("spur_i_data", bus.i_fill_data, 16'h0);
    cyc();
    inj = 1'b0;
    #1;
    chk("spur_busy", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
